pulse_train_gen: RTL and testbench

- Multi-channel, parametrised successor to the team's fixed double-pulse generator.
- On a rising edge of a trigger (e.g. UART command flag), emits a burst of up to MAX_PULSES pulses on NUM_CH outputs.
- First-pulse width, subsequent-pulse width, inter-pulse gap and pulse count are programmable, and latched at trigger.
- Per-channel enable and polarity; busy/done status returned to the command layer.

---
 rtl/pulse_train_pkg.sv | 20 ++
 rtl/trig_edge_det.sv | 27 ++
 rtl/pulse_train_gen.sv | 145 ++++++++++++++
 tb/tb_pulse_train_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// ============================================================================
// Module  : pulse_train_pkg
// Brief   : State encoding and default widths shared by the pulse train blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_train_pkg;

    localparam int c_cnt_w_default       = 21;
    localparam int c_cnt_pulse_w_default = 4;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_high = 2'd1;
    localparam logic [1:0] c_st_low  = 2'd2;
    localparam logic [1:0] c_st_fin  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/trig_edge_det.sv
// ============================================================================
// Module  : trig_edge_det
// Brief   : One-register rising-edge detector for command trigger flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d;

    // Reset to 1 so a trigger held high across reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) r_sig_d <= 1'b1;
        else     r_sig_d <= i_sig;
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// Module  : pulse_train_gen
// Brief   : Triggered multi-channel pulse burst generator with busy/done status.
//           Define PULSE_TRAIN_RETRIG_EN to restart bursts on a busy trigger.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = c_cnt_w_default,
    parameter int CNT_PULSE_W = c_cnt_pulse_w_default
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   trig_in,
    input  logic [CNT_W-1:0]       pulse_width1,
    input  logic [CNT_W-1:0]       pulse_width2,
    input  logic [CNT_W-1:0]       pulse_gap,
    input  logic [CNT_PULSE_W-1:0] pulse_count,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [NUM_CH-1:0]      ch_pol,
    output logic [NUM_CH-1:0]      pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    logic [1:0]             r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [CNT_PULSE_W-1:0] r_pnum, w_pnum_next;
    logic [CNT_W-1:0]       r_w1, r_w2, r_gap;
    logic [CNT_PULSE_W-1:0] r_count;
    logic [NUM_CH-1:0]      r_en, r_pol, r_pulse;
    logic [NUM_CH-1:0]      w_en_next, w_pol_next;
    logic [CNT_W-1:0]       w_hi_len;
    logic                   w_edge, w_start, w_latch;

    function automatic logic [CNT_W-1:0] f_eff(input logic [CNT_W-1:0] x);
        return (x == '0) ? CNT_W'(1) : x;
    endfunction

    trig_edge_det u_trig_edge_det (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_sig  (trig_in),
        .o_rise (w_edge)
    );

    assign w_hi_len = (r_pnum == CNT_PULSE_W'(1)) ? r_w1 : r_w2;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pnum_next  = r_pnum;
        w_latch      = 1'b0;
        case (r_state)
            c_st_high: begin
                if (r_cnt == f_eff(w_hi_len) - CNT_W'(1)) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_pnum == r_count) ? c_st_fin : c_st_low;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            c_st_low: begin
                if (r_cnt == f_eff(r_gap) - CNT_W'(1)) begin
                    w_cnt_next   = '0;
                    w_pnum_next  = r_pnum + CNT_PULSE_W'(1);
                    w_state_next = c_st_high;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            c_st_fin: w_state_next = c_st_idle;
            default:  ;
        endcase

`ifdef PULSE_TRAIN_RETRIG_EN
        w_start = w_edge;
`else
        w_start = w_edge & (r_state == c_st_idle);
`endif
        // A zero-length burst goes straight to FIN so done still strobes.
        if (w_start) begin
            w_latch      = 1'b1;
            w_cnt_next   = '0;
            w_pnum_next  = CNT_PULSE_W'(1);
            w_state_next = (pulse_count != '0) ? c_st_high : c_st_fin;
        end
    end

    assign w_en_next  = w_latch ? ch_en  : r_en;
    assign w_pol_next = w_latch ? ch_pol : r_pol;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_pnum  <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_gap   <= '0;
            r_count <= '0;
            r_en    <= '0;
            r_pol   <= '0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pnum  <= w_pnum_next;
            r_en    <= w_en_next;
            r_pol   <= w_pol_next;
            r_pulse <= ({NUM_CH{w_state_next == c_st_high}} & w_en_next) ^ w_pol_next;
            if (w_latch) begin
                r_w1    <= pulse_width1;
                r_w2    <= pulse_width2;
                r_gap   <= pulse_gap;
                r_count <= pulse_count;
            end
        end
    end

`ifdef PULSE_TRAIN_RETRIG_EN
    assign overrun = 1'b0;
`else
    logic r_overrun;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)                             r_overrun <= 1'b0;
        else if (w_edge && r_state != c_st_idle) r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;
`endif

    assign pulse_out = r_pulse;
    assign busy      = (r_state == c_st_high) || (r_state == c_st_low);
    assign done      = (r_state == c_st_fin);

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
// Module  : tb_pulse_train_gen
// Brief   : Directed scoreboard bench for pulse_train_gen.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        trig_in = 1'b0;
    logic [20:0] pulse_width1 = '0, pulse_width2 = '0, pulse_gap = '0;
    logic [3:0]  pulse_count = '0;
    logic [1:0]  ch_en = '0, ch_pol = '0;
    logic [1:0]  pulse_out;
    logic        busy, done, overrun;

    typedef struct {
        int         cyc;
        logic [1:0] pulse;
        logic       busy;
        logic       done;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef PULSE_TRAIN_RETRIG_EN
    localparam logic c_ovr5 = 1'b0;
`else
    localparam logic c_ovr5 = 1'b1;
`endif

    pulse_train_gen u_dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .trig_in      (trig_in),
        .pulse_width1 (pulse_width1),
        .pulse_width2 (pulse_width2),
        .pulse_gap    (pulse_gap),
        .pulse_count  (pulse_count),
        .ch_en        (ch_en),
        .ch_pol       (ch_pol),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: compares the expectation tagged for the current cycle.
    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            miscompares++;
            vectors++;
            $display("FAIL stale_expect cyc=%0d never checked", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ({pulse_out, busy, done, overrun} !== {e.pulse, e.busy, e.done, e.ovr}) begin
                miscompares++;
                $display("FAIL cyc%0d {pulse,busy,done,ovr} got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         cyc, pulse_out, busy, done, overrun, e.pulse, e.busy, e.done, e.ovr);
            end
        end
    end

    task automatic run(input int n, input logic [1:0] p, input logic b, input logic d,
                       input logic o);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cyc = cyc + 1; e.pulse = p; e.busy = b; e.done = d; e.ovr = o;
            sb.push_back(e);
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic cfg(input int w1, input int w2, input int gap, input int cnt,
                       input logic [1:0] en, input logic [1:0] pol);
        pulse_width1 = 21'(w1);
        pulse_width2 = 21'(w2);
        pulse_gap    = 21'(gap);
        pulse_count  = 4'(cnt);
        ch_en        = en;
        ch_pol       = pol;
    endtask

    initial begin
        @(posedge sys_clk);
        #1;
        run(2, 2'b00, 0, 0, 0);
        sys_rst = 1'b0;
        run(2, 2'b00, 0, 0, 0);

        // Three-pulse burst, trigger held high throughout
        cfg(3, 2, 4, 3, 2'b11, 2'b00);
        trig_in = 1'b1;
        run(3, 2'b11, 1, 0, 0);
        cfg(9, 7, 1, 1, 2'b00, 2'b11);
        run(4, 2'b00, 1, 0, 0);
        run(2, 2'b11, 1, 0, 0);
        run(4, 2'b00, 1, 0, 0);
        run(2, 2'b11, 1, 0, 0);
        run(1, 2'b00, 0, 1, 0);
        run(2, 2'b00, 0, 0, 0);

        // Polarity / enable: ch0 pulses, ch1 inverted and disabled
        trig_in = 1'b0;
        run(1, 2'b00, 0, 0, 0);
        cfg(5, 1, 1, 1, 2'b01, 2'b10);
        trig_in = 1'b1;
        run(5, 2'b11, 1, 0, 0);
        run(1, 2'b10, 0, 1, 0);
        run(2, 2'b10, 0, 0, 0);

        // Zero width and gap behave as one cycle
        trig_in = 1'b0;
        run(1, 2'b10, 0, 0, 0);
        cfg(0, 0, 0, 2, 2'b11, 2'b00);
        trig_in = 1'b1;
        run(1, 2'b11, 1, 0, 0);
        run(1, 2'b00, 1, 0, 0);
        run(1, 2'b11, 1, 0, 0);
        run(1, 2'b00, 0, 1, 0);
        run(1, 2'b00, 0, 0, 0);

        // Zero pulse count: done only
        trig_in = 1'b0;
        run(1, 2'b00, 0, 0, 0);
        cfg(3, 3, 3, 0, 2'b11, 2'b00);
        trig_in = 1'b1;
        run(1, 2'b00, 0, 1, 0);
        run(2, 2'b00, 0, 0, 0);

        // Second edge four cycles into a 10-cycle pulse
        trig_in = 1'b0;
        run(1, 2'b00, 0, 0, 0);
        cfg(10, 1, 1, 1, 2'b11, 2'b00);
        trig_in = 1'b1;
        run(2, 2'b11, 1, 0, 0);
        trig_in = 1'b0;
        run(1, 2'b11, 1, 0, 0);
        trig_in = 1'b1;
`ifdef PULSE_TRAIN_RETRIG_EN
        run(10, 2'b11, 1, 0, 0);
`else
        run(7, 2'b11, 1, 0, 1);
`endif
        run(1, 2'b00, 0, 1, c_ovr5);
        run(1, 2'b00, 0, 0, c_ovr5);

        // Reset mid-HIGH, trigger held across reset release
        trig_in = 1'b0;
        run(1, 2'b00, 0, 0, c_ovr5);
        cfg(5, 1, 1, 1, 2'b11, 2'b00);
        trig_in = 1'b1;
        run(2, 2'b11, 1, 0, c_ovr5);
        sys_rst = 1'b1;
        run(2, 2'b00, 0, 0, 0);
        sys_rst = 1'b0;
        run(3, 2'b00, 0, 0, 0);
        trig_in = 1'b0;
        run(1, 2'b00, 0, 0, 0);
        cfg(2, 1, 1, 1, 2'b11, 2'b00);
        trig_in = 1'b1;
        run(2, 2'b11, 1, 0, 0);
        run(1, 2'b00, 0, 1, 0);
        run(1, 2'b00, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge sys_clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            vectors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
